fpu_int_converter: RTL and testbench
====================================

Name: fpu_int_converter

Overview:
Pipelined single-precision conversion unit. It converts between IEEE-754 binary32 and signed two's-complement int32, in both directions.
- op=0 (F2I): float to int, the decoder direction.
- op=1 (I2F): int to float, the encoder direction.
It sits beside the FP add/sub unit in the arithmetic cluster and uses a valid/ready stream on both the input side and the output side.

Parameters:
TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operand presented
in_ready  out  1  unit accepts operand this cycle
op  in  1  0=F2I, 1=I2F
in_data  in  32  float bits (F2I) or int32 (I2F)
in_tag  in  TAG_W  opaque tag
out_valid  out  1  result presented
out_ready  in  1  downstream accepts result
out_data  out  32  int32 (F2I) or float bits (I2F)
out_tag  out  TAG_W  tag of the result
out_invalid  out  1  F2I NaN/Inf/out-of-range
out_inexact  out  1  result was rounded or truncated

Behaviour:
Pipeline structure
- Three stages: S1 unpack/classify (F2I) or abs/leading-zero count (I2F); S2 barrel shift; S3 round/negate/pack.
- Each stage holds a valid bit.
- Global stall: adv = !out_valid | out_ready. When adv is 1, all stages shift one place; when adv is 0, all stages hold.
- in_ready = adv. A transfer occurs on in_valid & in_ready.
- Latency is exactly 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 per cycle.
- op, tag and flags travel with the data. Results emerge in order.

Handshake rules
- While out_valid=1 and out_ready=0, all outputs stay stable.
- Mixed op sequences are legal back to back.

Reset
- Clears every stage valid bit. out_valid=0, out_data=0, out_tag=0, out_invalid=0, out_inexact=0.
- in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight operations; no result is emitted for them.

F2I rules (round toward zero)
- e = in_data[30:23], E = e-127, s = in_data[31].
- NaN: out_data=0x7FFFFFFF, invalid=1.
- Inf: out_data=0x7FFFFFFF if s=0, 0x80000000 if s=1; invalid=1.
- E<0 (includes zeros and denormals): out_data=0; inexact = (in_data[30:0]!=0).
- E>=31: in_data==0xCF000000 gives 0x80000000 with no flags. Otherwise saturate by sign as for Inf, invalid=1.
- 0<=E<=30: mag = {1,frac23}.
  - If E>=23, shift left by E-23.
  - If E<23, shift right by 23-E; inexact = OR of the shifted-out bits.
  - If s=1, result = -mag.
- invalid and inexact are mutually exclusive.

I2F rules (round to nearest, ties to even)
- Input 0: out_data=0x00000000, no flags.
- Otherwise:
  - m = |in_data|. For 0x80000000, m=2^31 with no overflow.
  - lz = leading-zero count of m, range 0..31.
  - n = m << lz, so n[31]=1.
  - Exponent = 158 - lz.
  - mant = n[30:8], guard g = n[7], sticky st = |n[6:0].
  - Round up when g & (st | mant[0]).
  - A mantissa carry-out increments the exponent and zeroes mant. The largest exponent possible is 158, so there is no overflow.
  - inexact = |n[7:0]. invalid=0.
  - Sign bit = in_data[31].

Decomposition:
Shared package fpu_pkg holds:
- constants: FP_BIAS=127, FP_EXP_MAX=8'hFF, INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000, I2F_EXP_BASE=158;
- an op enum: OP_F2I=0, OP_I2F=1;
- a stage-payload struct: valid, op, sign, shift amount, magnitude, sticky, flags, tag.

One sub-module: fpu_lzc32, a combinational 32-bit leading-zero counter built as a 5-level binary reduction, used by S1.

Test Plan:
- I2F 0x00000001 -> 0x3F800000, no flags, out_valid exactly 3 cycles after acceptance.
- I2F 0x01000001 -> 0x4B800000 inexact=1 (tie rounds to even); I2F 0x01000003 -> 0x4B800002 inexact=1 (tie rounds up to even); I2F 0x80000000 -> 0xCF000000 no flags.
- F2I 0xC0490FDB (-3.14159) -> 0xFFFFFFFD inexact=1; F2I 0x3F000000 (0.5) -> 0 inexact=1; F2I 0xCF000000 -> 0x80000000 no flags.
- F2I 0x7F800000 -> 0x7FFFFFFF invalid=1; F2I 0xFF800000 -> 0x80000000 invalid=1; F2I 0x7FC00000 -> 0x7FFFFFFF invalid=1; F2I 0x4F000000 -> 0x7FFFFFFF invalid=1.
- Back-to-back stream of 8 mixed ops with distinct tags, out_ready low for 5 cycles mid-stream:
  - in_ready drops while stalled;
  - no result is lost or duplicated;
  - order and tags are preserved;
  - outputs are stable during the stall.
- Assert rst with 3 ops in flight -> out_valid=0 the next cycle, none of those results ever appear, and the next accepted op completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the float/int conversion unit.
// Holds the binary32/int32 constants, the operation encoding and the
// payload record that travels down the three pipeline stages.
package fpu_pkg;

  localparam logic [7:0]  FP_BIAS      = 8'd127;
  localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;
  localparam logic [31:0] INT_MAX      = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN      = 32'h8000_0000;
  localparam logic [7:0]  I2F_EXP_BASE = 8'd158;

  // Biased exponents bounding the in-range F2I window (E = 23 and E = 31).
  localparam logic [7:0]  F2I_EXP_INT  = FP_BIAS + 8'd23;
  localparam logic [7:0]  F2I_EXP_SAT  = FP_BIAS + 8'd31;
  // -2^31 as a float: the single E = 31 value that is exactly representable.
  localparam logic [31:0] FP_INT_MIN   = 32'hCF00_0000;

  typedef enum logic {
    OP_F2I = 1'b0,
    OP_I2F = 1'b1
  } op_e;

  // Stage payload. The tag rides in parallel registers because its width is
  // a parameter of the unit rather than of the package.
  typedef struct packed {
    logic        valid;
    op_e         op;
    logic        sign;     // negate the magnitude (F2I) / sign bit (I2F)
    logic        shl;      // 1: shift magnitude left, 0: shift right
    logic [4:0]  shamt;    // shift amount; for I2F also the leading-zero count
    logic [31:0] mag;      // magnitude, or the finished result for F2I specials
    logic        sticky;   // OR of bits dropped by a right shift
    logic        invalid;
    logic        inexact;
  } stage_t;

endpackage

// File: rtl/fpu_lzc32.sv
// 32-bit leading-zero counter, purely combinational.
// Built as a 5-level binary reduction: each node reports whether its half
// is all zero and the leading-zero count within it.
//   data  : value to scan
//   count : number of leading zeros (0..31, meaningful when zero = 0)
//   zero  : data is all zeros
module fpu_lzc32 (
  input  logic [31:0] data,
  output logic [4:0]  count,
  output logic        zero
);

  logic [15:0] z1;
  logic [15:0] c1;
  logic [7:0]  z2;
  logic [1:0]  c2 [8];
  logic [3:0]  z3;
  logic [2:0]  c3 [4];
  logic [1:0]  z4;
  logic [3:0]  c4 [2];

  // At every level: if the upper half is empty, the count is the half-width
  // plus the lower half's count; otherwise it is the upper half's count.
  for (genvar j = 0; j < 16; j++) begin : g_l1
    assign z1[j] = ~(data[2*j+1] | data[2*j]);
    assign c1[j] = ~data[2*j+1];
  end

  for (genvar j = 0; j < 8; j++) begin : g_l2
    assign z2[j] = z1[2*j+1] & z1[2*j];
    assign c2[j] = z1[2*j+1] ? {1'b1, c1[2*j]} : {1'b0, c1[2*j+1]};
  end

  for (genvar j = 0; j < 4; j++) begin : g_l3
    assign z3[j] = z2[2*j+1] & z2[2*j];
    assign c3[j] = z2[2*j+1] ? {1'b1, c2[2*j]} : {1'b0, c2[2*j+1]};
  end

  for (genvar j = 0; j < 2; j++) begin : g_l4
    assign z4[j] = z3[2*j+1] & z3[2*j];
    assign c4[j] = z3[2*j+1] ? {1'b1, c3[2*j]} : {1'b0, c3[2*j+1]};
  end

  assign zero  = z4[1] & z4[0];
  assign count = z4[1] ? {1'b1, c4[0]} : {1'b0, c4[1]};

endmodule

// File: rtl/fpu_int_converter.sv
// Pipelined binary32 <-> int32 conversion unit with valid/ready streams.
//   op = OP_F2I: float bits -> int32, round toward zero, saturating
//   op = OP_I2F: int32 -> float bits, round to nearest even
// Stages: S1 classify / abs + leading-zero count, S2 barrel shift,
// S3 round / negate / pack (the output register). One global stall.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          operand handshake (in_ready = advance)
//   op, in_data, in_tag        operation, operand bits, opaque tag
//   out_valid/out_ready        result handshake
//   out_data, out_tag          result bits and the tag of that operation
//   out_invalid, out_inexact   F2I NaN/Inf/range error; result was rounded
module fpu_int_converter
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_invalid,
  output logic             out_inexact
);

  logic             adv;
  stage_t           s1, s1_d, s2, s2_d;
  logic [TAG_W-1:0] tag1, tag2;

  // The whole pipe moves together; it only freezes while a result waits.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1: classify (F2I) / abs + LZC (I2F) ----------------
  logic [31:0] abs_val;
  logic [4:0]  lz;
  logic        lz_zero;
  logic [7:0]  exp_f;
  logic [22:0] frac_f;

  // Two's-complement negate of 0x80000000 yields 0x80000000 = 2^31 unsigned.
  assign abs_val = in_data[31] ? (~in_data + 32'd1) : in_data;
  assign exp_f   = in_data[30:23];
  assign frac_f  = in_data[22:0];

  fpu_lzc32 u_lzc (
    .data  (abs_val),
    .count (lz),
    .zero  (lz_zero)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so that no
    // path through the branches can leave it unassigned and infer a latch.
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.op    = op_e'(op);
    s1_d.shl   = 1'b1;
    if (op_e'(op) == OP_I2F) begin
      // Zero leaves an all-zero payload, which S3 packs as +0.0.
      if (!lz_zero) begin
        s1_d.sign  = in_data[31];
        s1_d.shamt = lz;
        s1_d.mag   = abs_val;
      end
    end else if (exp_f == FP_EXP_MAX && frac_f != '0) begin
      s1_d.mag     = INT_MAX;
      s1_d.invalid = 1'b1;
    end else if (exp_f >= F2I_EXP_SAT) begin
      // Infinity and |x| >= 2^31 saturate; -2^31 itself is exact.
      if (in_data == FP_INT_MIN) begin
        s1_d.mag = INT_MIN;
      end else begin
        s1_d.mag     = in_data[31] ? INT_MIN : INT_MAX;
        s1_d.invalid = 1'b1;
      end
    end else if (exp_f < FP_BIAS) begin
      s1_d.inexact = |in_data[30:0];
    end else begin
      s1_d.sign = in_data[31];
      s1_d.mag  = {8'b0, 1'b1, frac_f};
      if (exp_f >= F2I_EXP_INT) begin
        s1_d.shamt = 5'(exp_f - F2I_EXP_INT);
      end else begin
        s1_d.shl   = 1'b0;
        s1_d.shamt = 5'(F2I_EXP_INT - exp_f);
      end
    end
  end

  // ---------------- S2: barrel shift ----------------
  logic [31:0] low_mask;

  always_comb begin
    s2_d     = s1;
    low_mask = ~(32'hFFFF_FFFF << s1.shamt);
    s2_d.mag = s1.shl ? (s1.mag << s1.shamt) : (s1.mag >> s1.shamt);
    // Bits below the shift amount; only lost when the shift is rightward,
    // which S3 accounts for.
    s2_d.sticky = s1.sticky | (|(s1.mag & low_mask));
  end

  // ---------------- S3: round / negate / pack ----------------
  logic [31:0] res_d;
  logic        inv_d, inx_d;
  logic [7:0]  i2f_exp;
  logic [23:0] i2f_mant;
  logic        round_up;

  always_comb begin
    res_d    = '0;
    inv_d    = 1'b0;
    inx_d    = 1'b0;
    i2f_exp  = I2F_EXP_BASE - {3'b0, s2.shamt};
    // Guard = mag[7], sticky = mag[6:0], lsb = mag[8]: ties go to even.
    round_up = s2.mag[7] & ((|s2.mag[6:0]) | s2.mag[8]);
    // A carry out of the 23-bit mantissa leaves it zero and bumps the exponent.
    i2f_mant = {1'b0, s2.mag[30:8]} + {23'b0, round_up};
    if (s2.op == OP_F2I) begin
      res_d = s2.sign ? -s2.mag : s2.mag;
      inv_d = s2.invalid;
      inx_d = s2.inexact | (s2.sticky & ~s2.shl);
    end else if (s2.mag[31]) begin
      res_d = {s2.sign, i2f_exp + {7'b0, i2f_mant[23]}, i2f_mant[22:0]};
      inx_d = |s2.mag[7:0];
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the valid bits and the visible outputs are reset; the
      // stage payloads are don't-care until their valid bit is set.
      s1.valid    <= 1'b0;
      s2.valid    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else if (adv) begin
      s1        <= s1_d;
      tag1      <= in_tag;
      s2        <= s2_d;
      tag2      <= tag1;
      out_valid <= s2.valid;
      // Bubbles leave the last result on the outputs.
      if (s2.valid) begin
        out_data    <= res_d;
        out_tag     <= tag2;
        out_invalid <= inv_d;
        out_inexact <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_fpu_int_converter.sv
// Self-checking bench for fpu_int_converter: a table of directed vectors
// with hand-computed results, then a stalled mixed stream and a reset
// with operations in flight.
module tb_fpu_int_converter;

  localparam int TAG_W = 4;
  localparam int NV    = 22;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_invalid;
  logic             out_inexact;

  fpu_int_converter #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .in_data     (in_data),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_invalid (out_invalid),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] din;
    logic [31:0] dout;
    logic        inv;
    logic        inx;
  } vec_t;

  vec_t vecs [NV];

  // Checks the output bundle against one table entry and its tag.
  task automatic check_result(input string pfx, input int i, input logic [TAG_W-1:0] tag);
    check($sformatf("%s data v%0d", pfx, i), out_data, vecs[i].dout);
    check($sformatf("%s tag v%0d", pfx, i), 32'(out_tag), 32'(tag));
    check($sformatf("%s invalid v%0d", pfx, i), 32'(out_invalid), 32'(vecs[i].inv));
    check($sformatf("%s inexact v%0d", pfx, i), 32'(out_inexact), 32'(vecs[i].inx));
  endtask

  // One isolated operation: accept, then measure edges until out_valid.
  task automatic run_vec(input int i, input logic [TAG_W-1:0] tag);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    op       = vecs[i].op;
    in_data  = vecs[i].din;
    in_tag   = tag;
    #1;
    check($sformatf("in_ready v%0d", i), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency v%0d", i), 32'(lat), 32'd3);
    check_result("vec", i, tag);
  endtask

  // Eight mixed ops back to back, out_ready low for five cycles.
  task automatic run_stream();
    int seq [8] = '{0, 8, 1, 9, 2, 16, 3, 17};
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall_cycles = 0;
    int extra = 0;
    logic stalled_prev = 1'b0;
    logic [31:0] hold_data = '0;
    logic [TAG_W-1:0] hold_tag = '0;
    logic hold_inv = 1'b0;
    logic hold_inx = 1'b0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 10);
      if (sent < 8) begin
        in_valid = 1'b1;
        op       = vecs[seq[sent]].op;
        in_data  = vecs[seq[sent]].din;
        in_tag   = TAG_W'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        check("stall valid", 32'(out_valid), 32'd1);
        check("stall data", out_data, hold_data);
        check("stall tag", 32'(out_tag), 32'(hold_tag));
        check("stall flags", {30'b0, out_invalid, out_inexact}, {30'b0, hold_inv, hold_inx});
      end
      if (out_valid && !out_ready) begin
        check("stall in_ready", 32'(in_ready), 32'd0);
        stall_cycles++;
        stalled_prev = 1'b1;
        hold_data    = out_data;
        hold_tag     = out_tag;
        hold_inv     = out_invalid;
        hold_inx     = out_inexact;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        check_result("stream", seq[got], TAG_W'(got + 1));
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream count", 32'(got), 32'd8);
    check("stream stall cycles", 32'(stall_cycles), 32'd5);
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("stream extra results", 32'(extra), 32'd0);
  endtask

  // Three ops in flight, held by back-pressure, then reset.
  task automatic run_reset_flush();
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      op       = vecs[k].op;
      in_data  = vecs[k].din;
      in_tag   = TAG_W'(9 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flushed results", 32'(seen), 32'd0);
    run_vec(5, 4'hE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            op    in_data        expected       inv   inx
    vecs[0]  = '{1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0100_0001, 32'h4B80_0000, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 32'h0100_0003, 32'h4B80_0002, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_tag", 32'(out_tag), 32'd0);
    check("reset out_invalid", 32'(out_invalid), 32'd0);
    check("reset out_inexact", 32'(out_inexact), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i, TAG_W'(i));

    run_stream();
    run_reset_flush();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
